// File: rtl/play_time_ctrl.sv
// Elapsed mm:ss play-time sequencer: 1 s prescaler, BCD elapsed counter and end-of-track detection.
// Defining PLAY_TIME_SEEK_EN adds 5 s forward/back seek inputs.
module play_time_ctrl #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
`ifdef PLAY_TIME_SEEK_EN
  input  logic        seek_fwd,
  input  logic        seek_back,
`endif
  input  logic [15:0] end_time,
  output logic [15:0] cur_time,
  output logic [1:0]  state,
  output logic        sec_tick,
  output logic        done
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_time;
  logic             r_tick;
  logic             r_done;

  state_t           w_nxt_state;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [15:0]      w_nxt_time;
  logic             w_nxt_tick;
  logic             w_nxt_done;
  logic             w_tick_hit;
  logic             w_end_hit;

  // Packed BCD mm:ss +1 s, saturating at 99:59.
  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t == 16'h9959) begin
      r = t;
    end else if (t[3:0] != 4'd9) begin
      r[3:0] = t[3:0] + 4'd1;
    end else if (t[7:4] != 4'd5) begin
      r[3:0] = 4'd0;
      r[7:4] = t[7:4] + 4'd1;
    end else if (t[11:8] != 4'd9) begin
      r[7:0]  = 8'h00;
      r[11:8] = t[11:8] + 4'd1;
    end else begin
      r[11:0]  = 12'h000;
      r[15:12] = t[15:12] + 4'd1;
    end
    return r;
  endfunction

`ifdef PLAY_TIME_SEEK_EN
  logic [15:0] w_fwd_time;
  logic [15:0] w_back_time;

  // Packed BCD mm:ss +5 s, saturating at 99:59.
  function automatic logic [15:0] bcd_add5(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] < 4'd5) begin
      r[3:0] = t[3:0] + 4'd5;
    end else if (t[7:4] != 4'd5) begin
      r[3:0] = t[3:0] - 4'd5;
      r[7:4] = t[7:4] + 4'd1;
    end else if (t[15:8] == 8'h99) begin
      r = 16'h9959;
    end else if (t[11:8] != 4'd9) begin
      r[3:0]  = t[3:0] - 4'd5;
      r[7:4]  = 4'd0;
      r[11:8] = t[11:8] + 4'd1;
    end else begin
      r[3:0]   = t[3:0] - 4'd5;
      r[11:4]  = 8'h00;
      r[15:12] = t[15:12] + 4'd1;
    end
    return r;
  endfunction

  // Packed BCD mm:ss -5 s, saturating at 00:00.
  function automatic logic [15:0] bcd_sub5(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] >= 4'd5) begin
      r[3:0] = t[3:0] - 4'd5;
    end else if (t[7:4] != 4'd0) begin
      r[3:0] = t[3:0] + 4'd5;
      r[7:4] = t[7:4] - 4'd1;
    end else if (t[15:8] == 8'h00) begin
      r = 16'h0000;
    end else if (t[11:8] != 4'd0) begin
      r[3:0]  = t[3:0] + 4'd5;
      r[7:4]  = 4'd5;
      r[11:8] = t[11:8] - 4'd1;
    end else begin
      r[3:0]   = t[3:0] + 4'd5;
      r[7:4]   = 4'd5;
      r[11:8]  = 4'd9;
      r[15:12] = t[15:12] - 4'd1;
    end
    return r;
  endfunction

  assign w_fwd_time  = ((end_time != 16'h0000) && (bcd_add5(r_time) > end_time)) ? end_time
                                                                                  : bcd_add5(r_time);
  assign w_back_time = bcd_sub5(r_time);
`endif

  assign w_tick_hit = (r_cnt == CNT_LAST);
  // Packed BCD orders the same as the time it encodes, so a plain unsigned compare suffices.
  assign w_end_hit  = (end_time != 16'h0000) && (r_time >= end_time);

  // Next-state, prescaler and time update with stop > start > pause (> seek) priority.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_time  = r_time;
    w_nxt_tick  = 1'b0;
    w_nxt_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nxt_state = ST_PLAY;
          w_nxt_cnt   = {CNT_W{1'b0}};
          w_nxt_time  = 16'h0000;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = {CNT_W{1'b0}};
          w_nxt_time  = 16'h0000;
        end else if (w_end_hit) begin
          w_nxt_state = ST_DONE;
          w_nxt_done  = 1'b1;
        end else if (pause) begin
          w_nxt_state = ST_PAUSE;
`ifdef PLAY_TIME_SEEK_EN
        end else if (seek_fwd) begin
          w_nxt_cnt   = {CNT_W{1'b0}};
          w_nxt_time  = w_fwd_time;
        end else if (seek_back) begin
          w_nxt_cnt   = {CNT_W{1'b0}};
          w_nxt_time  = w_back_time;
`endif
        end else if (w_tick_hit) begin
          w_nxt_cnt   = {CNT_W{1'b0}};
          w_nxt_time  = bcd_inc(r_time);
          w_nxt_tick  = 1'b1;
        end else begin
          w_nxt_cnt   = r_cnt + CNT_W'(1);
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = {CNT_W{1'b0}};
          w_nxt_time  = 16'h0000;
        end else if (start) begin
          w_nxt_state = ST_PLAY;
`ifdef PLAY_TIME_SEEK_EN
        end else if (seek_fwd) begin
          w_nxt_cnt   = {CNT_W{1'b0}};
          w_nxt_time  = w_fwd_time;
        end else if (seek_back) begin
          w_nxt_cnt   = {CNT_W{1'b0}};
          w_nxt_time  = w_back_time;
`endif
        end else begin
          w_nxt_state = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (stop) begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = {CNT_W{1'b0}};
          w_nxt_time  = 16'h0000;
        end else if (start) begin
          w_nxt_state = ST_PLAY;
          w_nxt_cnt   = {CNT_W{1'b0}};
          w_nxt_time  = 16'h0000;
        end else begin
          w_nxt_state = ST_DONE;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_cnt   = {CNT_W{1'b0}};
        w_nxt_time  = 16'h0000;
      end
    endcase
  end

  // State, prescaler, elapsed time and pulse registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_time  <= 16'h0000;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_time  <= w_nxt_time;
      r_tick  <= w_nxt_tick;
      r_done  <= w_nxt_done;
    end
  end

  assign cur_time = r_time;
  assign state    = r_state;
  assign sec_tick = r_tick;
  assign done     = r_done;

endmodule

// File: tb/tb_play_time_ctrl.sv
// Self-checking bench for play_time_ctrl: directed scenarios plus random commands against a seconds-based model.
module tb_play_time_ctrl;
  localparam int N = 4;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start     = 1'b0;
  logic        pause     = 1'b0;
  logic        stop      = 1'b0;
  logic [15:0] end_time  = 16'h0000;
  logic [15:0] cur_time;
  logic [1:0]  state;
  logic        sec_tick;
  logic        done;
`ifdef PLAY_TIME_SEEK_EN
  logic        seek_fwd  = 1'b0;
  logic        seek_back = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed time kept as plain seconds.
  int m_state;
  int m_sec;
  int m_pre;
  bit m_tick;
  bit m_done;

  logic [15:0] tgt_a [3] = '{16'h0059, 16'h0959, 16'h9959};
  logic [15:0] nxt_a [3] = '{16'h0100, 16'h1000, 16'h9959};

  play_time_ctrl #(.TICK_DIV(N)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
`ifdef PLAY_TIME_SEEK_EN
    .seek_fwd (seek_fwd),
    .seek_back(seek_back),
`endif
    .end_time (end_time),
    .cur_time (cur_time),
    .state    (state),
    .sec_tick (sec_tick),
    .done     (done)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int s);
    int m;
    int ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [19:0] exp_vec();
    return {2'(m_state), to_bcd(m_sec), m_tick, m_done};
  endfunction

  task automatic model_reset();
    m_state = 0; m_sec = 0; m_pre = 0; m_tick = 1'b0; m_done = 1'b0;
  endtask

  // One clock: model computes from the inputs the DUT is about to sample, then both advance.
  task automatic cycle();
    int ns, nsec, npre, esec;
    bit ntick, ndone, hit;
    ns = m_state; nsec = m_sec; npre = m_pre; ntick = 1'b0; ndone = 1'b0;
    esec = from_bcd(end_time);
    hit  = (end_time != 16'h0000) && (m_sec >= esec);
    case (m_state)
      0: if (start) begin ns = 1; nsec = 0; npre = 0; end
      1: begin
        if (stop) begin ns = 0; nsec = 0; npre = 0; end
        else if (hit) begin ns = 3; ndone = 1'b1; end
        else if (pause) ns = 2;
`ifdef PLAY_TIME_SEEK_EN
        else if (seek_fwd) begin
          nsec = (m_sec + 5 > 5999) ? 5999 : m_sec + 5;
          if (end_time != 16'h0000 && nsec > esec) nsec = esec;
          npre = 0;
        end
        else if (seek_back) begin nsec = (m_sec > 5) ? m_sec - 5 : 0; npre = 0; end
`endif
        else if (m_pre == N - 1) begin
          npre = 0; ntick = 1'b1; nsec = (m_sec < 5999) ? m_sec + 1 : 5999;
        end
        else npre = m_pre + 1;
      end
      2: begin
        if (stop) begin ns = 0; nsec = 0; npre = 0; end
        else if (start) ns = 1;
`ifdef PLAY_TIME_SEEK_EN
        else if (seek_fwd) begin
          nsec = (m_sec + 5 > 5999) ? 5999 : m_sec + 5;
          if (end_time != 16'h0000 && nsec > esec) nsec = esec;
          npre = 0;
        end
        else if (seek_back) begin nsec = (m_sec > 5) ? m_sec - 5 : 0; npre = 0; end
`endif
      end
      default: begin
        if (stop) begin ns = 0; nsec = 0; npre = 0; end
        else if (start) begin ns = 1; nsec = 0; npre = 0; end
      end
    endcase
    @(posedge sys_clk);
    m_state = ns; m_sec = nsec; m_pre = npre; m_tick = ntick; m_done = ndone;
    #1;
  endtask

  task automatic run_to(input logic [15:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cycle();
      ok = (cur_time == target);
    end
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cycle(); stop = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++;
    if ({state, cur_time, sec_tick, done} !== 20'h00000) begin
      errors++;
      $display("FAIL reset_values: got %h want 00000", {state, cur_time, sec_tick, done});
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) begin
      cycle();
      checks++;
      if ({state, cur_time, sec_tick, done} !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle: got %h want %h", {state, cur_time, sec_tick, done}, exp_vec());
      end
    end
  endtask

  task automatic test_basic_end();
    int ticks, dones, first_tick;
    ticks = 0; dones = 0; first_tick = -1;
    end_time = 16'h0003;
    pulse_start();
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL start_latency: state got %0d want 1", state);
    end
    for (int i = 1; i <= 20; i++) begin
      cycle();
      checks++;
      if ({state, cur_time, sec_tick, done} !== exp_vec()) begin
        errors++;
        $display("FAIL basic_model: cycle %0d got %h want %h", i, {state, cur_time, sec_tick, done}, exp_vec());
      end
      if (sec_tick) begin
        ticks++;
        if (first_tick < 0) first_tick = i;
      end
      if (done) dones++;
    end
    checks++;
    if (first_tick != N) begin
      errors++;
      $display("FAIL first_tick: got cycle %0d want %0d", first_tick, N);
    end
    checks++;
    if (ticks != 3 || dones != 1) begin
      errors++;
      $display("FAIL basic_counts: ticks %0d dones %0d want 3 and 1", ticks, dones);
    end
    checks++;
    if (state !== 2'd3 || cur_time !== 16'h0003) begin
      errors++;
      $display("FAIL basic_final: state %0d time %h want 3 0003", state, cur_time);
    end
  endtask

  task automatic test_carry();
    bit ok;
    bit seen;
    pulse_stop();
    end_time = 16'h0000;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      run_to(tgt_a[k], 6000 * N + 20, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL carry_reach: never reached %h, at %h", tgt_a[k], cur_time);
      end
      seen = 1'b0;
      for (int i = 0; i < N + 1 && !seen; i++) begin
        cycle();
        seen = sec_tick;
      end
      checks++;
      if ({cur_time, sec_tick} !== {nxt_a[k], 1'b1}) begin
        errors++;
        $display("FAIL carry_next: got %h tick %b want %h tick 1", cur_time, sec_tick, nxt_a[k]);
      end
      checks++;
      if ({state, cur_time, sec_tick, done} !== exp_vec()) begin
        errors++;
        $display("FAIL carry_model: got %h want %h", {state, cur_time, sec_tick, done}, exp_vec());
      end
    end
    pulse_stop();
  endtask

  task automatic test_pause_resume();
    logic [15:0] held;
    int cnt;
    bit seen;
    end_time = 16'h0000;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < N + 2 && !seen; i++) begin
      cycle();
      seen = sec_tick;
    end
    cycle();
    pause = 1'b1; cycle(); pause = 1'b0;
    held = cur_time;
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL pause_enter: state got %0d want 2", state);
    end
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (cur_time !== held || sec_tick !== 1'b0 || state !== 2'd2) begin
        errors++;
        $display("FAIL pause_hold: time %h tick %b state %0d want %h 0 2", cur_time, sec_tick, state, held);
      end
    end
    pulse_start();
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 2 * N && !seen; i++) begin
      cycle();
      cnt++;
      seen = sec_tick;
    end
    checks++;
    if (!seen || cnt != N - 1 || cur_time !== to_bcd(from_bcd(held) + 1)) begin
      errors++;
      $display("FAIL resume_tick: after %0d cycles time %h want %0d cycles time %h",
               cnt, cur_time, N - 1, to_bcd(from_bcd(held) + 1));
    end
    pulse_stop();
  endtask

  task automatic test_unknown_length();
    int ticks, dones;
    ticks = 0; dones = 0;
    end_time = 16'h0000;
    pulse_start();
    for (int i = 0; i < 200 * N + 10 && ticks < 200; i++) begin
      cycle();
      if (sec_tick) ticks++;
      if (done) dones++;
    end
    checks++;
    if (ticks != 200 || dones != 0 || cur_time !== 16'h0320 || state !== 2'd1) begin
      errors++;
      $display("FAIL unknown_len: ticks %0d dones %0d time %h state %0d want 200 0 0320 1",
               ticks, dones, cur_time, state);
    end
    end_time = 16'h0300;
    cycle();
    checks++;
    if (state !== 2'd3 || done !== 1'b1) begin
      errors++;
      $display("FAIL end_drop: state %0d done %b want 3 1", state, done);
    end
    cycle();
    checks++;
    if (state !== 2'd3 || done !== 1'b0 || cur_time !== 16'h0320) begin
      errors++;
      $display("FAIL done_once: state %0d done %b time %h want 3 0 0320", state, done, cur_time);
    end
  endtask

  task automatic test_stop_tick();
    bit ok;
    end_time = 16'h0000;
    pulse_start();
    run_to(16'h0007, 8 * N + 4, ok);
    repeat (N - 1) cycle();
    pulse_stop();
    checks++;
    if (!ok || {state, cur_time, sec_tick} !== 19'h00000) begin
      errors++;
      $display("FAIL stop_tick: reached %b state %0d time %h tick %b want 0 0000 0", ok, state, cur_time, sec_tick);
    end
    checks++;
    if ({state, cur_time, sec_tick, done} !== exp_vec()) begin
      errors++;
      $display("FAIL stop_model: got %h want %h", {state, cur_time, sec_tick, done}, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    pulse_start();
    repeat (3 * N + 1) cycle();
    checks++;
    if (state !== 2'd1 || cur_time !== 16'h0003) begin
      errors++;
      $display("FAIL pre_reset: state %0d time %h want 1 0003", state, cur_time);
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({state, cur_time, sec_tick, done} !== 20'h00000) begin
      errors++;
      $display("FAIL async_reset: got %h want 00000", {state, cur_time, sec_tick, done});
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      pause = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 49) == 0);
`ifdef PLAY_TIME_SEEK_EN
      seek_fwd  = ($urandom_range(0, 29) == 0);
      seek_back = ($urandom_range(0, 29) == 0);
`endif
      if ($urandom_range(0, 99) == 0)
        end_time = ($urandom_range(0, 3) == 0) ? 16'h0000 : to_bcd(int'($urandom_range(1, 40)));
      cycle();
      checks++;
      if ({state, cur_time, sec_tick, done} !== exp_vec()) begin
        errors++;
        $display("FAIL random_model: iter %0d got %h want %h", i, {state, cur_time, sec_tick, done}, exp_vec());
      end
    end
    start = 1'b0; pause = 1'b0; stop = 1'b0;
`ifdef PLAY_TIME_SEEK_EN
    seek_fwd = 1'b0; seek_back = 1'b0;
`endif
  endtask

`ifdef PLAY_TIME_SEEK_EN
  task automatic test_seek();
    bit ok;
    pulse_stop();
    end_time = 16'h0000;
    pulse_start();
    run_to(16'h0057, 60 * N, ok);
    pause = 1'b1; cycle(); pause = 1'b0;
    seek_fwd = 1'b1; cycle(); seek_fwd = 1'b0;
    checks++;
    if (!ok || cur_time !== 16'h0102) begin
      errors++;
      $display("FAIL seek_fwd: got %h want 0102", cur_time);
    end
    pulse_stop();
    pulse_start();
    run_to(16'h0003, 5 * N, ok);
    pause = 1'b1; cycle(); pause = 1'b0;
    seek_back = 1'b1; cycle(); seek_back = 1'b0;
    checks++;
    if (!ok || cur_time !== 16'h0000) begin
      errors++;
      $display("FAIL seek_back: got %h want 0000", cur_time);
    end
    pulse_stop();
    end_time = 16'h0300;
    pulse_start();
    run_to(16'h0258, 180 * N, ok);
    seek_fwd = 1'b1; cycle(); seek_fwd = 1'b0;
    checks++;
    if (!ok || cur_time !== 16'h0300 || state !== 2'd1) begin
      errors++;
      $display("FAIL seek_clamp: time %h state %0d want 0300 1", cur_time, state);
    end
    cycle();
    checks++;
    if (state !== 2'd3 || done !== 1'b1) begin
      errors++;
      $display("FAIL seek_done: state %0d done %b want 3 1", state, done);
    end
    pulse_stop();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_end();
    test_carry();
    test_pause_resume();
    test_unknown_length();
    test_stop_tick();
    test_async_reset();
`ifdef PLAY_TIME_SEEK_EN
    test_seek();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
